// File: rtl/mod_reduce_512_if.sv
// Bus bundle for the 512-bit modular reducer.
// The multiplier (or a bench) drives start/product/modulus and
// reads back valid/busy/err/result.
interface mod_reduce_512_if #(
   parameter int WIDTH    = 256,
   parameter int IN_WIDTH = 520
);
   logic                start;
   logic [IN_WIDTH-1:0] product;
   logic [WIDTH-1:0]    modulus;
   logic                valid;
   logic                busy;
   logic                err;
   logic [WIDTH-1:0]    result;

   modport master (
      output start, product, modulus,
      input  valid, busy, err, result
   );

   modport slave (
      input  start, product, modulus,
      output valid, busy, err, result
   );
endinterface

// File: rtl/mod_reduce_512.sv
// Bit-serial interleaved modular reducer: result = product[511:0] mod p.
// Each COMPUTE cycle shifts one product bit into r (r = 2r + bit) and
// subtracts p once if needed, which keeps r < p.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; operands latched on the start edge
// COMPUTE | one product bit per clock, MSB first (k = 511 .. 0)
// DONE    | result/err held, valid high until start drops
module mod_reduce_512 #(
   parameter int WIDTH     = 256,
   parameter int IN_WIDTH  = 520,
   parameter int USE_WIDTH = 512
) (
   input logic             clk,
   input logic             rst,
   mod_reduce_512_if.slave bus
);

   localparam int KW = $clog2(USE_WIDTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t               state, state_next;
   logic [USE_WIDTH-1:0] p_reg, p_next;
   logic [WIDTH-1:0]     m_reg, m_next;
   logic [WIDTH-1:0]     r, r_next;
   logic [KW-1:0]        k, k_next;
   logic [WIDTH-1:0]     result, result_next;
   logic                 err, err_next;
   logic                 valid, valid_next;
   logic                 busy, busy_next;

   // Product bits above USE_WIDTH are deliberately dropped.
   logic unused_hi;
   assign unused_hi = ^bus.product[IN_WIDTH-1:USE_WIDTH];

   // One reduction step, carried at WIDTH+1 bits so 2r+bit never overflows.
   logic [WIDTH:0] t;
   logic [WIDTH:0] p_wide;
   logic [WIDTH:0] t_red;
   logic           t_ge;

   assign p_wide = {1'b0, m_reg};
   assign t      = {r, 1'b0} + {{WIDTH{1'b0}}, p_reg[k]};
   assign t_ge   = (t >= p_wide);
   assign t_red  = t_ge ? (t - p_wide) : t;

   // Next-state and next-register values; everything defaults to hold.
   always_comb begin
      state_next  = state;
      p_next      = p_reg;
      m_next      = m_reg;
      r_next      = r;
      k_next      = k;
      result_next = result;
      err_next    = err;
      valid_next  = valid;
      busy_next   = 1'b0;

      case (state)
         IDLE: begin
            valid_next = 1'b0;
            if (bus.start) begin
               p_next     = bus.product[USE_WIDTH-1:0];
               m_next     = bus.modulus;
               r_next     = '0;
               k_next     = KW'(USE_WIDTH - 1);
               err_next   = 1'b0;
               state_next = COMPUTE;
            end
         end

         COMPUTE: begin
            // Zero modulus is caught on the first compute edge using the
            // latched copy, so the bus value after start never matters.
            if (m_reg == '0) begin
               err_next    = 1'b1;
               result_next = '0;
               state_next  = DONE;
            end else begin
               r_next = t_red[WIDTH-1:0];
               if (k == '0) begin
                  result_next = t_red[WIDTH-1:0];
                  state_next  = DONE;
               end else begin
                  k_next = k - KW'(1);
               end
            end
         end

         DONE: begin
            valid_next = 1'b1;
            if (!bus.start) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next == COMPUTE);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         p_reg  <= '0;
         m_reg  <= '0;
         r      <= '0;
         k      <= '0;
         result <= '0;
         err    <= 1'b0;
         valid  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_next;
         p_reg  <= p_next;
         m_reg  <= m_next;
         r      <= r_next;
         k      <= k_next;
         result <= result_next;
         err    <= err_next;
         valid  <= valid_next;
         busy   <= busy_next;
      end
   end

   assign bus.valid  = valid;
   assign bus.busy   = busy;
   assign bus.err    = err;
   assign bus.result = result;

endmodule

// File: doc/mod_reduce_512.md
Name: mod_reduce_512

Overview:
- Sequential modular reducer that consumes the 520-bit product bus from the 264x256 sequential multiplier and returns product mod p (256-bit).
- Sits directly downstream of the multiplier in the ECC field-multiply path.
- Uses the same start/valid level handshake as the multiplier, so the multiplier's valid can drive this block's start.
- Bit-serial interleaved reduction: one product bit per clock, r = 2r + bit, then a conditional subtract of p.

Parameters:
- WIDTH, 256, modulus and result width.
- IN_WIDTH, 520, width of the product input bus.
- USE_WIDTH, 512, number of product LSBs reduced; bits IN_WIDTH-1:USE_WIDTH are ignored.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset; rst=0 at a rising edge resets the block.
- start  input  1  level request; sampled only in IDLE.
- product  input  520  dividend; bits 511:0 used, bits 519:512 ignored.
- modulus  input  256  p; must be nonzero.
- valid  output  1  result/err valid; held while in DONE.
- busy  output  1  high in COMPUTE.
- err  output  1  modulus was zero at start.
- result  output  256  product mod p.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE; valid=0, busy=0, err=0, result=0; internal r=0, k=0.
  - Applies from any state, including mid-COMPUTE. The partial result is discarded; no valid pulse is produced.
- State IDLE: valid<=0.
  - If start=1, latch product[511:0] and modulus into internal registers, clear r=0, set k=511, clear err.
  - Go to COMPUTE. If the latched modulus is 0, go to DONE instead with err<=1 and result<=0.
  - After this edge, changes on product/modulus have no effect until the next start.
- State COMPUTE: busy=1. Each edge computes t = {r,1'b0} + P[k], which is 257 bits wide.
  - If t >= p then r <= t - p, else r <= t. t < 2p always holds, so one subtract suffices and the invariant r < p is maintained.
  - After processing k=0 (the 512th COMPUTE edge), result <= final r and go to DONE. Otherwise k <= k-1.
  - start is ignored during COMPUTE.
- State DONE: valid<=1; result and err held stable.
  - If start=0, go to IDLE. valid drops on the following edge, when IDLE executes.
  - If start stays 1, remain in DONE with valid held high. There is no auto-restart; a new operation requires start to go low and then high again.
- Latency: call the edge that samples start in IDLE E0.
  - result is updated at E512.
  - valid is first high after E513, i.e. 513 cycles after E0.
  - Zero-modulus path: valid is high after E2.
- Throughput: one operation per at least 515 cycles (E0 through E513, plus the cycle to return to IDLE).
- Width rules: all compare and subtract logic is 257 bits. No truncation until the write to result[255:0]. Modulus p=1 is legal and yields result 0.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Small values: product=100, modulus=7, start held high -> valid rises exactly 513 cycles after the sampling edge; result=2, err=0.
- Boundary operands:
  - product=p with p=secp256k1 prime (2^256-2^32-977) -> result=0.
  - product=p-1 -> result=p-1.
  - product=(p-1)^2 -> result=1.
  - product=2^512-1 with bits 519:512 set to 0xFF -> result equals (2^512-1) mod p, so the upper bits are ignored.
- Zero modulus: modulus=0, product=5, start=1 -> err=1, result=0, valid high after 2 edges. The next start with modulus=7 clears err.
- Input stability: start a reduction of 100 mod 7, then change product and modulus every cycle during COMPUTE -> result is still 2.
- Reset mid-operation: assert rst=0 for one edge at cycle 200 of COMPUTE -> next cycle shows state IDLE, valid=0, busy=0, result=0. A fresh start with 100 mod 7 then completes normally with result=2.
- Handshake chaining: hold start high for 600 cycles -> valid stays high with no recompute. Drop start -> valid low 2 edges later. Raise start again with 1000 mod 13 -> result=12.
